// File: rtl/fifo_drain_serializer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_drain_serializer
// Purpose  : Read-side companion to sync_fifo. Pops FIFO_DWIDTH-bit event
//            words from a show-ahead FIFO whenever it holds data and enable
//            is set, then emits each word as FIFO_DWIDTH/OUT_WIDTH beats on a
//            valid/ready stream, most-significant slice first. Sustains one
//            beat per cycle, including across word boundaries.
// Ports    :
//   clk         in   single clock, all logic rising-edge
//   rst_n       in   asynchronous active-low reset
//   enable      in   permission to pop new words (looked at on word boundaries)
//   fifo_empty  in   FIFO empty flag
//   fifo_rdata  in   FIFO head word (show-ahead, valid while not empty)
//   fifo_rd_en  out  one-cycle pop strobe to the FIFO
//   out_valid   out  beat valid
//   out_ready   in   downstream accepts the beat
//   out_data    out  beat payload
//   out_last    out  final beat of the current word
//   busy        out  a word is being serialized
//   words_sent  out  fully transmitted words, wraps at 2^16
// Revision : 1.0 - initial release
// ============================================================================
module fifo_drain_serializer #(
  parameter int FIFO_DWIDTH = 64,
  parameter int OUT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [FIFO_DWIDTH-1:0] fifo_rdata,
  output logic                   fifo_rd_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic [15:0]            words_sent
);

  localparam int NUM_BEATS = FIFO_DWIDTH / OUT_WIDTH;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Reject geometries that cannot be serialized into whole beats.
  generate
    if (((FIFO_DWIDTH % OUT_WIDTH) != 0) || (NUM_BEATS < 2)) begin : g_bad_params
      $error("fifo_drain_serializer: OUT_WIDTH must divide FIFO_DWIDTH into at least two beats");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]             state_q, state_d;
  logic [FIFO_DWIDTH-1:0] sreg_q, sreg_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [15:0]            words_sent_q, words_sent_d;

  logic accept;     // beat handshake completes this cycle
  logic last_beat;  // the beat currently presented is the final one
  logic pop;        // take the FIFO head word this cycle

  assign last_beat = (beat_q == LAST_BEAT);
  assign accept    = out_valid & out_ready;

  // A new word may be taken while idle, or on the same edge that the final
  // beat of the current word is accepted; the latter is what removes the
  // bubble between back-to-back words. rst_n is folded in so that the pop
  // strobe is forced low during reset even though IDLE would otherwise allow
  // it to follow the FIFO flag.
  assign pop = rst_n & enable & ~fifo_empty &
               ((state_q == ST_IDLE) |
                ((state_q == ST_SEND) & accept & last_beat));

  assign fifo_rd_en = pop;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sreg_q       <= '0;
      beat_q       <= '0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      beat_q       <= beat_d;
      words_sent_q <= words_sent_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // Final beat leaves SEND only when no follow-on word is popped.
        if (accept && last_beat && !pop) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next-value logic
  // --------------------------------------------------------------------------
  always_comb begin
    sreg_d       = sreg_q;
    beat_d       = beat_q;
    words_sent_d = words_sent_q;

    if (pop) begin
      sreg_d = fifo_rdata;
      beat_d = '0;
    end else if (accept && !last_beat) begin
      // The next slice moves into the MSB position that drives out_data.
      sreg_d = sreg_q << OUT_WIDTH;
      beat_d = beat_q + BEAT_W'(1);
    end

    if (accept && last_beat) begin
      words_sent_d = words_sent_q + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  // Everything here is a function of registered state only, so while
  // out_ready is low the presented beat cannot change.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    if (state_q == ST_SEND) begin
      out_valid = 1'b1;
      out_data  = sreg_q[FIFO_DWIDTH-1 -: OUT_WIDTH];
      out_last  = last_beat;
      busy      = 1'b1;
    end
  end

  assign words_sent = words_sent_q;

endmodule
`default_nettype wire

// File: doc/fifo_drain_serializer.md
# fifo_drain_serializer

Read-side companion to `sync_fifo`: pops FIFO_DWIDTH-bit event words from the FIFO whenever it is non-empty and emits each word as FIFO_DWIDTH/OUT_WIDTH narrower beats on a valid/ready stream, MSB slice first. It sits between the event FIFO and the narrow off-chip/readout link. It sustains one beat per cycle under continuous `out_ready`, including back-to-back words.

## Interface
- FIFO_DWIDTH, 64, FIFO word width; must equal the connected `sync_fifo` FIFO_DWIDTH.
- OUT_WIDTH, 16, output beat width; must divide FIFO_DWIDTH exactly (NUM_BEATS = FIFO_DWIDTH/OUT_WIDTH ≥ 2).
- clk  input  1  single clock, all logic rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- enable  input  1  1 = permitted to pop new words; sampled only at word boundaries.
- fifo_empty  input  1  FIFO `empty` flag.
- fifo_rdata  input  FIFO_DWIDTH  FIFO `rdata`; head word, valid whenever `fifo_empty`=0 (show-ahead).
- fifo_rd_en  output  1  FIFO `rd_en`; one-cycle pop strobe.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accepts beat.
- out_data  output  OUT_WIDTH  beat payload.
- out_last  output  1  marks final beat of a word.
- busy  output  1  1 while a word is held (state SEND).
- words_sent  output  16  count of fully transmitted words, wraps at 2^16.

## Operation
- States: IDLE, SEND. Internal: shift register `sreg` [FIFO_DWIDTH], beat counter `beat` [$clog2(NUM_BEATS)].
- Reset (async, rst_n=0): state=IDLE, sreg=0, beat=0, words_sent=0; outputs fifo_rd_en=0, out_valid=0, out_data=0, out_last=0, busy=0.
- `pop` = enable & ~fifo_empty & (state==IDLE | (state==SEND & out_valid & out_ready & out_last)).
- fifo_rd_en = `pop` (combinational; never asserted when fifo_empty=1).
- On `pop` edge: sreg <= fifo_rdata, beat <= 0, state <= SEND.
- IDLE, no pop: hold; out_valid=0.
- SEND: out_valid=1, out_data = sreg[FIFO_DWIDTH-1 -: OUT_WIDTH], out_last = (beat==NUM_BEATS-1), busy=1.
- Beat accepted (out_valid & out_ready), not last: sreg <= sreg << OUT_WIDTH, beat <= beat+1.
- Last beat accepted: words_sent <= words_sent+1; if `pop` reload from FIFO (stay SEND), else state <= IDLE.
- out_ready=0 in SEND: out_data, out_last, out_valid held stable; no FIFO activity.
- enable deasserted mid-word: current word completes all beats; no new pop until enable=1.
- Ordering: words in FIFO order, beats MSB slice first; no word dropped or duplicated.

## Timing
- Pop-to-first-beat latency: fifo_rd_en high in cycle N → out_valid high in cycle N+1.
- From FIFO write while IDLE and enable=1: empty falls (FIFO-dependent) → fifo_rd_en same cycle → out_valid next cycle.
- Throughput with out_ready=1: NUM_BEATS cycles per word, zero bubble between words while FIFO non-empty; fifo_rd_en pulses once per NUM_BEATS cycles coincident with out_last acceptance.
- words_sent updates the edge after last-beat acceptance.
- out_valid, once high, stays high until accepted (no retraction).
- Reset mid-word: in-flight word discarded (already popped), outputs to reset values immediately.

## Test plan
- Single word: reset, write 64'h1111_2222_3333_4444, enable=1, out_ready=1 → one fifo_rd_en pulse; beats 16'h1111,16'h2222,16'h3333,16'h4444 on consecutive cycles, out_last only on 16'h4444; words_sent=1; return to IDLE, busy=0.
- Back-to-back: fill 16 random words, out_ready=1 → 64 beats in 64 consecutive cycles, out_valid never drops, fifo_rd_en every 4th cycle, data matches write order, words_sent=16, FIFO empty at end.
- Backpressure: one word, out_ready toggled 0/1 randomly and held 0 for 5 cycles on beat 2 → out_data/out_last stable while stalled, all 4 beats delivered in order, exactly one fifo_rd_en.
- Empty/enable gating: FIFO empty with enable=1 for 20 cycles → fifo_rd_en=0, out_valid=0; 3 words with enable=0 → no pops; drop enable during beat 1 of word 0 → word 0 finishes (4 beats), no further pops until enable=1.
- Reset mid-word: assert rst_n=0 between beats 2 and 3 → out_valid, fifo_rd_en, out_last, busy, words_sent 0 immediately; after release remaining FIFO words transmit correctly.
- Counter wrap: force/preload 65535 completed words (or shorten via force) → next word completion gives words_sent=0.
